dac_ch_sched: RTL and testbench
===============================

Name: dac_ch_sched

Overview:
Round-robin scheduler that shares one SPI DAC writer between two channel requesters (DAC-A, DAC-B). Each requester presents a 12-bit code. The scheduler grants one requester and builds the 16-bit frame {ctrl nibble, code}. It pulses the writer start, waits for end-of-write and acknowledges the requester. It sits between the per-channel update sources and the SPI write engine, replacing a fixed A-then-B sequencer.

Parameters:
CtrlA, 4'b0011, control nibble prepended for channel A
CtrlB, 4'b1011, control nibble prepended for channel B
TimeoutW, 16, width of the end-of-write watchdog counter
TimeoutMax, 16'd1000, clk cycles to wait for eow_i before aborting

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active-high
reqa_i  input  1  channel A update request, level, held until acka_o
codea_i  input  12  channel A code, stable while reqa_i high
reqb_i  input  1  channel B update request, level, held until ackb_o
codeb_i  input  12  channel B code, stable while reqb_i high
eow_i  input  1  end-of-write pulse from SPI writer
strw_o  output  1  one-cycle start pulse to SPI writer
din_o  output  16  frame to SPI writer, valid from strw_o until eow_i
acka_o  output  1  one-cycle done pulse to requester A
ackb_o  output  1  one-cycle done pulse to requester B
busy_o  output  1  high in any state except IDLE
err_o  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rst_i=1): state=IDLE; strw_o=0; din_o=16'h0000; acka_o=ackb_o=0; busy_o=0; err_o=0; last-granted=B, so A wins the first tie; watchdog=0.
- States: IDLE, LOAD, START, WAIT, DONE.
- IDLE: if any req is high, pick a winner and go to LOAD.
  - Single request: grant it.
  - Both high: grant the channel not granted last.
- LOAD, 1 cycle:
  - Register din_o = {CtrlA, codea_i} or {CtrlB, codeb_i}.
  - Record the granted channel.
  - Code is sampled here only; later code changes are ignored for this frame.
- START, 1 cycle: strw_o=1; clear watchdog; go to WAIT.
- WAIT:
  - Hold din_o.
  - On eow_i=1, go to DONE.
  - Otherwise increment the watchdog.
  - At watchdog==TimeoutMax-1 without eow_i: err_o=1 for 1 cycle, no ack, update last-granted, go to IDLE.
  - If eow_i and timeout coincide, eow_i wins: no err_o.
- DONE, 1 cycle:
  - Pulse ack of the granted channel; update last-granted.
  - Go to IDLE.
  - The requester must drop req the cycle after ack. A req still high in IDLE is treated as a new request.
- Latency:
  - req high in IDLE → strw_o at cycle +2.
  - eow_i → ack at cycle +1.
  - Minimum gap between consecutive strw_o = writer duration + 4 cycles.
- eow_i outside WAIT is ignored.
- A req dropped before ack does not abort a frame already in LOAD/START/WAIT; ack still pulses.
- Both reqs held continuously → grants strictly alternate A,B,A,B.
- Reset mid-frame: immediate return to reset values. The writer is not told; the integrator resets both blocks together.
- Watchdog counter saturates at TimeoutMax-1 and never wraps.

Optional Feature:
DAC_SKIP_SAME_EN
- Defined:
  - The block keeps a per-channel last-written 12-bit code plus a valid bit, set on DONE and cleared by reset.
  - In LOAD, if the granted code equals the stored code and valid=1: skip START/WAIT, go straight to DONE, pulse ack, no strw_o.
  - Watchdog-aborted frames do not update the stored code.
- Undefined: every request produces an SPI write; no storage registers are synthesized.

Test Plan:
- Reset then reqa_i=1, codea_i=12'h4D9 → strw_o at cycle 2 with din_o=16'h34D9; eow_i after 40 cycles → acka_o one cycle later; busy_o low after.
- reqa_i and reqb_i both high continuously, codeb_i=12'h9B2 → frames alternate 16'h34D9, 16'hB9B2, 16'h34D9; ack pulses alternate A,B,A.
- reqb_i raised while A is in WAIT → B's strw_o issued only after acka_o, and B is granted next.
- No eow_i after strw_o → err_o pulses exactly TimeoutMax cycles after the START cycle; no ack; next pending req then serviced.
- rst_i asserted mid-WAIT → all outputs zero asynchronously; after release reqb_i is granted normally; a late eow_i is ignored.
- With DAC_SKIP_SAME_EN: write A=12'h4D9 twice → second request gives acka_o 2 cycles after req with no strw_o. Then A=12'h26D → normal write with din_o=16'h326D.

Source files
------------

// File: rtl/dac_ch_sched.sv
// dac_ch_sched: round-robin arbiter sharing one SPI DAC writer between two channels.
// Optional `define DAC_SKIP_SAME_EN: suppress writes whose code matches the last one written.
module dac_ch_sched #(
  parameter logic [3:0]          CtrlA      = 4'b0011,
  parameter logic [3:0]          CtrlB      = 4'b1011,
  parameter int                  TimeoutW   = 16,
  parameter logic [TimeoutW-1:0] TimeoutMax = 16'd1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reqa_i,
  input  logic [11:0] codea_i,
  input  logic        reqb_i,
  input  logic [11:0] codeb_i,
  input  logic        eow_i,
  output logic        strw_o,
  output logic [15:0] din_o,
  output logic        acka_o,
  output logic        ackb_o,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    DONE
  } state_t;

  localparam logic [TimeoutW-1:0] WdLast = TimeoutMax - 1'b1;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic [15:0]         din_q, din_d;
  logic [TimeoutW-1:0] wd_q, wd_d;
  logic                err_d;
  logic                wd_top;
  logic                skip;

  assign wd_top = (wd_q == WdLast);

`ifdef DAC_SKIP_SAME_EN
  logic [11:0] mem_a_q, mem_b_q;
  logic        vld_a_q, vld_b_q;

  assign skip = gnt_q ? (vld_b_q && (codeb_i == mem_b_q))
                      : (vld_a_q && (codea_i == mem_a_q));

  // remember the code of each channel's last completed frame
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_a_q <= '0;
      mem_b_q <= '0;
      vld_a_q <= 1'b0;
      vld_b_q <= 1'b0;
    end else if (state_q == DONE) begin
      if (gnt_q) begin
        mem_b_q <= din_q[11:0];
        vld_b_q <= 1'b1;
      end else begin
        mem_a_q <= din_q[11:0];
        vld_a_q <= 1'b1;
      end
    end
  end
`else
  assign skip = 1'b0;
`endif

  // state, grant, frame and watchdog registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      din_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      din_q   <= din_d;
      wd_q    <= wd_d;
    end
  end

  // next-state: arbitration, frame build, watchdog abort
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    din_d   = din_q;
    wd_d    = wd_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reqa_i || reqb_i) begin
          // A wins unless only B asks, or B lost last time
          gnt_d   = ~(reqa_i & (~reqb_i | last_q));
          state_d = LOAD;
        end
      end
      LOAD: begin
        din_d   = gnt_q ? {CtrlB, codeb_i}
                        : {CtrlA, codea_i};
        state_d = skip ? DONE : START;
      end
      START: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (eow_i) begin
          state_d = DONE;
        end else if (wd_top) begin
          err_d   = 1'b1;
          last_d  = gnt_q;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign strw_o = (state_q == START);
  assign acka_o = (state_q == DONE) && !gnt_q;
  assign ackb_o = (state_q == DONE) && gnt_q;
  assign busy_o = (state_q != IDLE);
  assign err_o  = err_d;
  assign din_o  = din_q;

endmodule

// File: tb/tb_dac_ch_sched.sv
// tb_dac_ch_sched: directed scoreboard bench for dac_ch_sched.
// Frames are queued on request and popped when strw_o fires.
module tb_dac_ch_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqa = 1'b0;
  logic        reqb = 1'b0;
  logic        eow = 1'b0;
  logic [11:0] codea = '0;
  logic [11:0] codeb = '0;
  logic        strw, acka, ackb, busy, err;
  logic [15:0] din;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int str_cnt = 0;
  int ack_cnt = 0;
  int acka_cnt = 0;
  int ackb_cnt = 0;
  int err_cnt = 0;
  int last_str_cyc = 0;
  int last_ack_cyc = 0;
  int last_err_cyc = 0;
  int ack_last = -1;
  logic [15:0] exp_q[$];

  dac_ch_sched dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .reqa_i (reqa),
    .codea_i(codea),
    .reqb_i (reqb),
    .codeb_i(codeb),
    .eow_i  (eow),
    .strw_o (strw),
    .din_o  (din),
    .acka_o (acka),
    .ackb_o (ackb),
    .busy_o (busy),
    .err_o  (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (strw) begin
        str_cnt++;
        last_str_cyc = cyc;
        if (exp_q.size() == 0) check("str_unexp", 1, 0);
        else check("frame", din, exp_q.pop_front());
      end
      if (acka || ackb) begin
        ack_cnt++;
        last_ack_cyc = cyc;
        ack_last = ackb ? 1 : 0;
        if (acka) acka_cnt++;
        if (ackb) ackb_cnt++;
      end
      if (err) begin
        err_cnt++;
        last_err_cyc = cyc;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_eow();
    eow = 1'b1;
    @(posedge clk);
    #1;
    eow = 1'b0;
  endtask

  task automatic wait_str(input string tag, input int bound);
    int s;
    bit ok;
    s = str_cnt;
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(posedge clk);
      #1;
      if (str_cnt != s) ok = 1;
    end
    if (!ok) check(tag, 0, 1);
  endtask

  task automatic wait_ack(input string tag, input int bound);
    int s;
    bit ok;
    s = ack_cnt;
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(posedge clk);
      #1;
      if (ack_cnt != s) ok = 1;
    end
    if (!ok) check(tag, 0, 1);
  endtask

  task automatic wait_err(input string tag, input int bound);
    int s;
    bit ok;
    s = err_cnt;
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(posedge clk);
      #1;
      if (err_cnt != s) ok = 1;
    end
    if (!ok) check(tag, 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
  endtask

  initial begin
    int c0;
    int s0;
    int e0;

    // reset values
    wait_cyc(2);
    @(negedge clk);
    check("rst_outs", {strw, acka, ackb, busy, err}, 5'b0);
    check("rst_din", din, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cyc(1);

    // single A write, latency and ack timing
    codea = 12'h4D9;
    exp_q.push_back(16'h34D9);
    reqa = 1'b1;
    c0 = cyc;
    wait_str("t1_str_to", 10);
    check("t1_str_lat", last_str_cyc - c0, 2);
    check("t1_busy", busy, 1'b1);
    wait_cyc(39);
    e0 = cyc;
    pulse_eow();
    wait_ack("t1_ack_to", 10);
    check("t1_ack_lat", last_ack_cyc - e0, 1);
    check("t1_ack_ch", ack_last, 0);
    reqa = 1'b0;
    wait_cyc(1);
    check("t1_idle", busy, 1'b0);

    // both held: strict alternation, A first after reset
    do_reset();
    codeb = 12'h9B2;
    exp_q.push_back(16'h34D9);
    exp_q.push_back(16'hB9B2);
    exp_q.push_back(16'h34D9);
    reqa = 1'b1;
    reqb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_str("t2_str_to", 10);
      wait_cyc(3);
      pulse_eow();
      wait_ack("t2_ack_to", 10);
      check("t2_ack_order", ack_last, k % 2);
    end
    reqa = 1'b0;
    reqb = 1'b0;
    wait_cyc(2);
    check("t2_frames_left", exp_q.size(), 0);

    // B arrives while A writes: served only after A's ack
    exp_q.push_back(16'h34D9);
    reqa = 1'b1;
    wait_str("t3_stra_to", 10);
    exp_q.push_back(16'hB9B2);
    reqb = 1'b1;
    s0 = str_cnt;
    wait_cyc(5);
    check("t3_no_early_b", str_cnt, s0);
    pulse_eow();
    wait_ack("t3_acka_to", 10);
    check("t3_ack_a", ack_last, 0);
    reqa = 1'b0;
    wait_str("t3_strb_to", 10);
    check("t3_b_after_a", last_str_cyc > last_ack_cyc, 1);
    pulse_eow();
    wait_ack("t3_ackb_to", 10);
    check("t3_ack_b", ack_last, 1);
    reqb = 1'b0;
    wait_cyc(2);

    // watchdog abort, then pending B wins over still-held A
    exp_q.push_back(16'h34D9);
    reqa = 1'b1;
    wait_str("t4_str_to", 10);
    s0 = last_str_cyc;
    reqb = 1'b1;
    c0 = acka_cnt;
    exp_q.push_back(16'hB9B2);
    exp_q.push_back(16'h34D9);
    wait_err("t4_err_to", 1100);
    check("t4_err_lat", last_err_cyc - s0, 1000);
    check("t4_no_ack", acka_cnt, c0);
    wait_str("t4_strb_to", 10);
    pulse_eow();
    wait_ack("t4_ackb_to", 10);
    check("t4_ack_b", ack_last, 1);
    reqb = 1'b0;
    wait_str("t4_stra_to", 10);
    pulse_eow();
    wait_ack("t4_acka_to", 10);
    check("t4_ack_a", ack_last, 0);
    reqa = 1'b0;
    wait_cyc(2);
    check("t4_err_once", err_cnt, 1);

    // async reset mid-WAIT, late eow ignored
    exp_q.push_back(16'hB9B2);
    reqb = 1'b1;
    wait_str("t5_str_to", 10);
    wait_cyc(3);
    rst = 1'b1;
    reqb = 1'b0;
    #1;
    check("t5_async_outs", {strw, acka, ackb, busy, err}, 5'b0);
    check("t5_async_din", din, 16'h0000);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
    s0 = ack_cnt;
    pulse_eow();
    wait_cyc(3);
    check("t5_late_eow", ack_cnt, s0);
    check("t5_late_busy", busy, 1'b0);
    exp_q.push_back(16'hB9B2);
    reqb = 1'b1;
    wait_str("t5_str2_to", 10);
    pulse_eow();
    wait_ack("t5_ack_to", 10);
    check("t5_ack_b", ack_last, 1);
    reqb = 1'b0;
    wait_cyc(2);

    // repeated code on A
    do_reset();
    codea = 12'h4D9;
    exp_q.push_back(16'h34D9);
    reqa = 1'b1;
    wait_str("t6_str1_to", 10);
    pulse_eow();
    wait_ack("t6_ack1_to", 10);
    reqa = 1'b0;
    wait_cyc(2);
    s0 = str_cnt;
`ifdef DAC_SKIP_SAME_EN
    c0 = cyc;
    reqa = 1'b1;
    wait_ack("t6_skip_to", 10);
    check("t6_skip_lat", last_ack_cyc - c0, 2);
    check("t6_skip_nostr", str_cnt, s0);
    reqa = 1'b0;
`else
    exp_q.push_back(16'h34D9);
    reqa = 1'b1;
    wait_str("t6_rpt_to", 10);
    check("t6_rpt_str", str_cnt, s0 + 1);
    pulse_eow();
    wait_ack("t6_rpt_ack_to", 10);
    reqa = 1'b0;
`endif
    wait_cyc(2);
    codea = 12'h26D;
    exp_q.push_back(16'h326D);
    reqa = 1'b1;
    wait_str("t6_str2_to", 10);
    pulse_eow();
    wait_ack("t6_ack2_to", 10);
    check("t6_ack_a", ack_last, 0);
    reqa = 1'b0;
    wait_cyc(3);
    check("final_frames_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
